// File: rtl/mmu_pkg.sv
// Shared definitions for the SBC09 MMU blocks: I/O page, register maps,
// CMD/status bit positions and the map engine state encoding.
package mmu_pkg;

   localparam logic [15:0] MMU_IO_PAGE = 16'hFE00;

   // Register window offsets inside the I/O page
   localparam logic [7:0]  MMU_INT_OFS = 8'h10;   // mmu_int task/control registers
   localparam logic [7:0]  MAP_REG_OFS = 8'h18;   // map engine window (8 bytes)

   // Map engine register selects (offset within the window)
   localparam logic [2:0]  MAP_SRC  = 3'd0;
   localparam logic [2:0]  MAP_DST  = 3'd1;
   localparam logic [2:0]  MAP_FILL = 3'd2;
   localparam logic [2:0]  MAP_CMD  = 3'd3;

   // CMD write bits
   localparam int CMD_START = 0;
   localparam int CMD_MODE  = 1;
   localparam int CMD_IEN   = 2;

   // CMD read (status) bits
   localparam int STS_BUSY  = 7;
   localparam int STS_DONE  = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HREQ,
      ST_RD,
      ST_LAT,
      ST_WR,
      ST_WREC,
      ST_REL
   } map_state_e;

endpackage

// File: rtl/mmu_map_ctl_if.sv
// CPU-side bus of the map engine: E phase, address/data, bus status and the
// halt/interrupt lines back to the 6809.
interface mmu_map_ctl_if;
   logic        E;
   logic [15:0] ADDR;
   logic        RnW;
   logic        BA;
   logic        BS;
   logic [7:0]  DATA_in;
   logic [7:0]  DATA_out;
   logic        DATA_oe;
   logic        nHALT;
   logic        nIRQ;

   modport master (
      output E, ADDR, RnW, BA, BS, DATA_in,
      input  DATA_out, DATA_oe, nHALT, nIRQ
   );

   modport slave (
      input  E, ADDR, RnW, BA, BS, DATA_in,
      output DATA_out, DATA_oe, nHALT, nIRQ
   );
endinterface

// File: rtl/mmu_map_regs.sv
// Map engine register window: E falling-edge commit, SRC/DST/FILL/CMD
// registers, read mux and the done/interrupt flag.
module mmu_map_regs
   import mmu_pkg::*;
#(
   parameter logic [15:0] IO_PAGE = MMU_IO_PAGE,
   parameter logic [7:0]  REG_OFS = MAP_REG_OFS
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        e,
   input  logic [15:0] addr,
   input  logic        rnw,
   input  logic [7:0]  data_in,
   input  logic        busy,
   input  logic        set_done,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        n_irq,
   output logic        start,
   output logic [4:0]  src,
   output logic [4:0]  dst,
   output logic [7:0]  fill,
   output logic        mode
);

   logic        e_q;
   logic [4:0]  src_q, src_d;
   logic [4:0]  dst_q, dst_d;
   logic [7:0]  fill_q, fill_d;
   logic        mode_q, mode_d;
   logic        ien_q, ien_d;
   logic        done_q, done_d;

   logic [15:0] ofs;
   logic        hit, commit, wr, rd;
   logic [2:0]  sel;

   // Decode window hit and commit strobes, compute next register values
   always_comb begin
      ofs    = addr - (IO_PAGE + {8'h00, REG_OFS});
      hit    = (ofs[15:3] == 13'd0);
      sel    = ofs[2:0];
      commit = e_q & ~e;
      wr     = commit & hit & ~rnw & ~busy;
      rd     = commit & hit & rnw;
      src_d  = src_q;
      dst_d  = dst_q;
      fill_d = fill_q;
      mode_d = mode_q;
      ien_d  = ien_q;
      done_d = done_q;
      start  = 1'b0;
      if (wr) begin
         case (sel)
            MAP_SRC:  src_d  = data_in[4:0];
            MAP_DST:  dst_d  = data_in[4:0];
            MAP_FILL: fill_d = data_in;
            MAP_CMD: begin
               mode_d = data_in[CMD_MODE];
               ien_d  = data_in[CMD_IEN];
               start  = data_in[CMD_START];
            end
            default: ;
         endcase
      end
      if (rd && sel == MAP_CMD) done_d = 1'b0;
      if (set_done)             done_d = 1'b1;
   end

   // Register state; E is delayed one CLKX4 for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q    <= 1'b0;
         src_q  <= 5'd0;
         dst_q  <= 5'd0;
         fill_q <= 8'h00;
         mode_q <= 1'b0;
         ien_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         e_q    <= e;
         src_q  <= src_d;
         dst_q  <= dst_d;
         fill_q <= fill_d;
         mode_q <= mode_d;
         ien_q  <= ien_d;
         done_q <= done_d;
      end
   end

   // Read mux; offsets above CMD read as zero
   always_comb begin
      data_out = 8'h00;
      case (sel)
         MAP_SRC:  data_out = {3'b000, src_q};
         MAP_DST:  data_out = {3'b000, dst_q};
         MAP_FILL: data_out = fill_q;
         MAP_CMD:  data_out = {busy, done_q, 3'b000, ien_q, mode_q, 1'b0};
         default:  data_out = 8'h00;
      endcase
   end

   assign data_oe = e & rnw & hit;
   assign n_irq   = ~(done_q & ien_q);
   assign src     = src_q;
   assign dst     = dst_q;
   assign fill    = fill_q;
   assign mode    = mode_q;

endmodule

// File: rtl/mmu_map_ctl.sv
// MMU page-table copy/fill engine. Halts the CPU, takes the MMU RAM port
// from mmu_int, copies or fills one 8-entry task map, then hands it back.
module mmu_map_ctl
   import mmu_pkg::*;
#(
   parameter logic [15:0] IO_PAGE = MMU_IO_PAGE,
   parameter logic [7:0]  REG_OFS = MAP_REG_OFS
) (
   input  logic        CLKX4,
   input  logic        nRESET,
   mmu_map_ctl_if.slave bus,
   input  logic [7:0]  cpu_mmu_addr,
   input  logic        cpu_mmu_nrd,
   input  logic        cpu_mmu_nwr,
   input  logic [7:0]  cpu_mmu_dout,
   input  logic        cpu_mmu_doe,
   output logic [7:0]  MMU_ADDR,
   output logic        MMU_nRD,
   output logic        MMU_nWR,
   output logic [7:0]  MMU_DATA_out,
   output logic        MMU_DATA_oe,
   input  logic [7:0]  MMU_DATA_in,
   output logic        busy
);

   map_state_e  state_q;
   logic [2:0]  idx_q;
   logic        ack_q;
   logic [7:0]  tmp_q;
   logic        nhalt_q;
   logic        own_q;
   logic [7:0]  eaddr_q;
   logic        enrd_q;
   logic        enwr_q;
   logic        edoe_q;

   logic        start, mode, set_done;
   logic [4:0]  src, dst;
   logic [7:0]  fill;

   assign busy     = (state_q != ST_IDLE);
   assign set_done = (state_q == ST_REL) & ~bus.BA;

   mmu_map_regs #(
      .IO_PAGE (IO_PAGE),
      .REG_OFS (REG_OFS)
   ) u_regs (
      .clk      (CLKX4),
      .rst_n    (nRESET),
      .e        (bus.E),
      .addr     (bus.ADDR),
      .rnw      (bus.RnW),
      .data_in  (bus.DATA_in),
      .busy     (busy),
      .set_done (set_done),
      .data_out (bus.DATA_out),
      .data_oe  (bus.DATA_oe),
      .n_irq    (bus.nIRQ),
      .start    (start),
      .src      (src),
      .dst      (dst),
      .fill     (fill),
      .mode     (mode)
   );

   // Engine FSM; port drive values are registered alongside the next state
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= ST_IDLE;
         idx_q   <= 3'd0;
         ack_q   <= 1'b0;
         tmp_q   <= 8'h00;
         nhalt_q <= 1'b1;
         own_q   <= 1'b0;
         eaddr_q <= 8'h00;
         enrd_q  <= 1'b1;
         enwr_q  <= 1'b1;
         edoe_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  idx_q   <= 3'd0;
                  ack_q   <= 1'b0;
                  nhalt_q <= 1'b0;
                  state_q <= ST_HREQ;
               end
            end
            // Wait for BA&BS on two consecutive edges before touching the port
            ST_HREQ: begin
               if (bus.BA && bus.BS) begin
                  if (ack_q) begin
                     own_q <= 1'b1;
                     if (mode) begin
                        state_q <= ST_WR;
                        eaddr_q <= {dst, idx_q};
                        enrd_q  <= 1'b1;
                        enwr_q  <= 1'b0;
                        edoe_q  <= 1'b1;
                     end else begin
                        state_q <= ST_RD;
                        eaddr_q <= {src, idx_q};
                        enrd_q  <= 1'b0;
                        enwr_q  <= 1'b1;
                        edoe_q  <= 1'b0;
                     end
                  end else begin
                     ack_q <= 1'b1;
                  end
               end else begin
                  ack_q <= 1'b0;
               end
            end
            ST_RD: state_q <= ST_LAT;
            ST_LAT: begin
               tmp_q   <= MMU_DATA_in;
               state_q <= ST_WR;
               eaddr_q <= {dst, idx_q};
               enrd_q  <= 1'b1;
               enwr_q  <= 1'b0;
               edoe_q  <= 1'b1;
            end
            ST_WR: begin
               enwr_q  <= 1'b1;
               state_q <= ST_WREC;
            end
            ST_WREC: begin
               if (idx_q == 3'd7) begin
                  state_q <= ST_REL;
                  own_q   <= 1'b0;
                  nhalt_q <= 1'b1;
                  edoe_q  <= 1'b0;
               end else begin
                  idx_q <= idx_q + 3'd1;
                  if (mode) begin
                     state_q <= ST_WR;
                     eaddr_q <= {dst, idx_q + 3'd1};
                     enwr_q  <= 1'b0;
                  end else begin
                     state_q <= ST_RD;
                     eaddr_q <= {src, idx_q + 3'd1};
                     enrd_q  <= 1'b0;
                     edoe_q  <= 1'b0;
                  end
               end
            end
            ST_REL: begin
               if (!bus.BA) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.nHALT = nhalt_q;

   // Port mux: engine owns the MMU RAM only between RD and WREC
   assign MMU_ADDR     = own_q ? eaddr_q : cpu_mmu_addr;
   assign MMU_nRD      = own_q ? enrd_q  : cpu_mmu_nrd;
   assign MMU_nWR      = own_q ? enwr_q  : cpu_mmu_nwr;
   assign MMU_DATA_out = own_q ? (mode ? fill : tmp_q) : cpu_mmu_dout;
   assign MMU_DATA_oe  = own_q ? edoe_q  : cpu_mmu_doe;

endmodule
